// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack for the RISC fetch path.
// Latency: one cycle, registered outputs; en=0 stalls everything (no backpressure).
module pc_stack #(
    parameter int AW         = 5,
    parameter int DEPTH      = 4,
    parameter int RESET_ADDR = 0
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       ldpc,
    input  logic                       skip,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              adir,
    output logic [AW-1:0]              adpc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int SPW = $clog2(DEPTH+1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           push;
    logic [AW-1:0]  stack_q [DEPTH];
    logic [IW-1:0]  wr_idx, rd_idx;
    logic           full, empty;
    logic [AW-1:0]  pc_inc;

    assign full   = (sp_q == SPW'(DEPTH));
    assign empty  = (sp_q == '0);
    assign pc_inc = pc_q + AW'(1);
    assign wr_idx = IW'(sp_q);
    assign rd_idx = IW'(sp_q - SPW'(1));

    // One action per enabled cycle, priority ret > call > ldpc > skip > increment.
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (en) begin
            if (ret) begin
                if (!empty) begin
                    pc_d = stack_q[rd_idx];
                    sp_d = sp_q - SPW'(1);
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (call) begin
                // The jump is taken even when the push has to be dropped.
                pc_d = adir;
                if (!full) begin
                    push = 1'b1;
                    sp_d = sp_q + SPW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (ldpc) begin
                pc_d = adir;
            end else if (skip) begin
                pc_d = pc_q + AW'(2);
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            pc_q  <= AW'(RESET_ADDR);
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage is deliberately left out of reset; sp alone defines validity.
    always_ff @(posedge pclk) begin
        if (rst && push) begin
            stack_q[wr_idx] <= pc_inc;
        end
    end

    assign adpc      = pc_q;
    assign sp        = sp_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;

endmodule
